mem_access_ctrl: RTL and testbench



---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_access_ctrl.sv | 134 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory access front end.
// Covers the controller state encoding and a request record that benches can reuse.
package mem_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 3;
  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPT,
    RSP,
    CLEAR
  } state_t;

  typedef struct packed {
    logic                          write;
    logic [DEFAULT_ADDR_WIDTH-1:0] addr;
    logic [DEFAULT_DATA_WIDTH-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// Request-side front end for a single-port synchronous memory with a 1-cycle registered read.
// Turns a valid/ready request stream into memory strobes, returns read data, and runs a clear sequence.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_n;
  logic [ADDR_WIDTH-1:0] mem_addr_n;
  logic                  mem_wr_en_n, mem_rd_en_n;
  logic [DATA_WIDTH-1:0] mem_wdata_n, rsp_rdata_n;
  logic                  rsp_valid_n, clear_busy_n;

  // A pending clear pulse blocks acceptance so the clear wins over a same-cycle request.
  assign req_ready = (state == IDLE) && !clear_start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      clr_cnt    <= '0;
      mem_addr   <= '0;
      mem_wr_en  <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_wdata  <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      clear_busy <= 1'b0;
    end else begin
      state      <= state_n;
      clr_cnt    <= clr_cnt_n;
      mem_addr   <= mem_addr_n;
      mem_wr_en  <= mem_wr_en_n;
      mem_rd_en  <= mem_rd_en_n;
      mem_wdata  <= mem_wdata_n;
      rsp_valid  <= rsp_valid_n;
      rsp_rdata  <= rsp_rdata_n;
      clear_busy <= clear_busy_n;
    end
  end

  // Strobes default low each cycle; address, data and response hold unless a state updates them.
  always_comb begin
    state_n      = state;
    clr_cnt_n    = clr_cnt;
    mem_addr_n   = mem_addr;
    mem_wr_en_n  = 1'b0;
    mem_rd_en_n  = 1'b0;
    mem_wdata_n  = mem_wdata;
    rsp_valid_n  = rsp_valid;
    rsp_rdata_n  = rsp_rdata;
    clear_busy_n = 1'b0;

    case (state)
      IDLE: begin
        if (clear_start) begin
          state_n      = CLEAR;
          clr_cnt_n    = '0;
          mem_addr_n   = '0;
          mem_wr_en_n  = 1'b1;
          mem_wdata_n  = INIT_VALUE;
          clear_busy_n = 1'b1;
        end else if (req_valid) begin
          mem_addr_n = req_addr;
          if (req_write) begin
            mem_wr_en_n = 1'b1;
            mem_wdata_n = req_wdata;
          end else begin
            mem_rd_en_n = 1'b1;
            state_n     = RD_ISSUE;
          end
        end
      end

      RD_ISSUE: state_n = RD_CAPT;

      // Memory output is valid this cycle, one cycle after the read strobe.
      RD_CAPT: begin
        rsp_rdata_n = mem_rdata;
        rsp_valid_n = 1'b1;
        state_n     = RSP;
      end

      RSP: begin
        if (rsp_valid && rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end

      // Stop on the last address itself so the counter's wrap never matters.
      CLEAR: begin
        if (clr_cnt == LAST_ADDR) begin
          state_n = IDLE;
        end else begin
          clr_cnt_n    = clr_cnt + 1'b1;
          mem_addr_n   = clr_cnt + 1'b1;
          mem_wr_en_n  = 1'b1;
          mem_wdata_n  = INIT_VALUE;
          clear_busy_n = 1'b1;
        end
      end

      default: begin
        state_n     = IDLE;
        rsp_valid_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized self-checking bench for mem_access_ctrl driving a behavioural single-port memory.
// Expected read data comes from a bench-side array updated by the rules of each operation.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0, req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          clear_start = 1'b0, clear_busy;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en, mem_rd_en;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] mem_array [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_VALUE(8'hFF)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .clear_start(clear_start), .clear_busy(clear_busy),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Single-port synchronous memory with a registered read port.
  always @(posedge clk) begin
    if (mem_wr_en) mem_array[mem_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= mem_array[mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic write, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic clr, output logic accepted);
    req_valid   = valid;
    req_write   = write;
    req_addr    = addr;
    req_wdata   = wdata;
    clear_start = clr;
    #1;
    accepted = req_valid && req_ready;
    tick();
    req_valid   = 1'b0;
    req_write   = 1'b0;
    clear_start = 1'b0;
  endtask

  task automatic doWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    logic acc;
    applyStimulus(1'b1, 1'b1, addr, data, 1'b0, acc);
    checkOutput("wr_accept", acc, 1);
    checkOutput("wr_strobe", mem_wr_en, 1);
    checkOutput("wr_addr", mem_addr, addr);
    checkOutput("wr_data", mem_wdata, data);
    checkOutput("wr_no_rd", mem_rd_en, 0);
    ref_mem[addr] = data;
  endtask

  task automatic doRead(input logic [AW-1:0] addr, input int hold, input logic poke_clear);
    logic acc;
    logic [DW-1:0] exp;
    exp = ref_mem[addr];
    applyStimulus(1'b1, 1'b0, addr, DW'($urandom), 1'b0, acc);
    checkOutput("rd_accept", acc, 1);
    checkOutput("rd_strobe", mem_rd_en, 1);
    checkOutput("rd_addr", mem_addr, addr);
    checkOutput("rd_no_wr", mem_wr_en, 0);
    checkOutput("rd_ready_busy", req_ready, 0);
    tick();
    checkOutput("rd_strobe_off", mem_rd_en, 0);
    checkOutput("rd_rsp_early", rsp_valid, 0);
    tick();
    checkOutput("rsp_valid", rsp_valid, 1);
    checkOutput("rsp_data", rsp_rdata, exp);
    for (int i = 0; i < hold; i++) begin
      clear_start = poke_clear && (i == 0);
      tick();
      clear_start = 1'b0;
      checkOutput("hold_valid", rsp_valid, 1);
      checkOutput("hold_data", rsp_rdata, exp);
      checkOutput("hold_ready", req_ready, 0);
      if (poke_clear) checkOutput("clear_ignored", clear_busy, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("rsp_done", rsp_valid, 0);
    checkOutput("ready_after", req_ready, 1);
  endtask

  task automatic doClear(input logic with_req);
    logic acc;
    int cnt;
    applyStimulus(with_req, 1'b1, AW'($urandom), 8'h77, 1'b1, acc);
    checkOutput("clr_blocks_req", acc, 0);
    cnt = 0;
    while (clear_busy && cnt < 20) begin
      checkOutput("clr_addr", mem_addr, cnt);
      checkOutput("clr_wr", mem_wr_en, 1);
      checkOutput("clr_data", mem_wdata, 8'hFF);
      cnt++;
      tick();
    end
    checkOutput("clr_cycles", cnt, DEPTH);
    checkOutput("clr_wr_off", mem_wr_en, 0);
    checkOutput("clr_ready", req_ready, 1);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'hFF;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic acc;
    mem_req_t op;
    #12;
    checkOutput("rst_addr", mem_addr, 0);
    checkOutput("rst_wr", mem_wr_en, 0);
    checkOutput("rst_rd", mem_rd_en, 0);
    checkOutput("rst_wdata", mem_wdata, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_data", rsp_rdata, 0);
    checkOutput("rst_busy", clear_busy, 0);
    reset = 1'b0;
    tick();
    checkOutput("rst_ready", req_ready, 1);

    // Single write then read back, with one idle gap to see the strobe drop.
    doWrite(3'd3, 8'h5A);
    tick();
    checkOutput("wr_single_cycle", mem_wr_en, 0);
    doRead(3'd3, 0, 1'b0);

    for (int i = 0; i < DEPTH; i++) doWrite(AW'(i), DW'(8'h10 + i));
    tick();
    for (int i = 0; i < DEPTH; i++) doRead(AW'(i), 0, 1'b0);

    doRead(3'd2, 5, 1'b1);

    doClear(1'b1);
    for (int i = 0; i < DEPTH; i++) doRead(AW'(i), 0, 1'b0);

    // Reset while the read data is being captured.
    applyStimulus(1'b1, 1'b0, 3'd6, 8'h00, 1'b0, acc);
    checkOutput("pre_rst_accept", acc, 1);
    tick();
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_addr", mem_addr, 0);
    checkOutput("mid_rst_rd", mem_rd_en, 0);
    checkOutput("mid_rst_wr", mem_wr_en, 0);
    checkOutput("mid_rst_wdata", mem_wdata, 0);
    checkOutput("mid_rst_valid", rsp_valid, 0);
    checkOutput("mid_rst_data", rsp_rdata, 0);
    checkOutput("mid_rst_busy", clear_busy, 0);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("no_ghost_rsp", rsp_valid, 0);
    end
    doWrite(3'd7, 8'hA5);
    doRead(3'd7, 0, 1'b0);

    doWrite(3'd5, 8'h33);
    doRead(3'd5, 0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      int kind;
      kind = int'($urandom_range(0, 11));
      op.write = (kind < 6);
      op.addr  = AW'($urandom);
      op.wdata = DW'($urandom);
      if (kind == 11) doClear(1'($urandom));
      else if (op.write) doWrite(op.addr, op.wdata);
      else doRead(op.addr, int'($urandom_range(0, 3)), 1'($urandom));
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
